e_mdu: RTL and testbench
========================

E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have reset  input  1  asynchronous, active-low reset (0 = reset, acts immediately, independent of clk).
REQ-003 SHALL have E_MDUOp  input  4  operation: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9-15 treated as none.
REQ-004 SHALL have E_start  input  1  one-cycle pulse launching operation codes 1-4.
REQ-005 SHALL have E_WD1  input  32  operand A (rs, forwarded), supplied by the D->E pipeline register.
REQ-006 SHALL have E_WD2  input  32  operand B (rt, forwarded).
REQ-007 SHALL have E_busy  output  1  high while an operation is in flight.
REQ-008 SHALL have E_HI  output  32  architectural HI register.
REQ-009 SHALL have E_LO  output  32  architectural LO register.
REQ-010 SHALL have E_MDUResult  output  32  combinational: E_HI if op=MFHI, E_LO if op=MFLO, else 0.

Function
REQ-011 SHALL hold a 4-bit down-counter cnt; E_busy = (cnt != 0), registered, no combinational path from E_start.
REQ-012 SHALL, on an edge with E_start=1, cnt=0 and op in {1..4}, load cnt=5 (MULT/MULTU) or cnt=10 (DIV/DIVU) and capture the computed result into internal hi_tmp/lo_tmp.
REQ-013 SHALL decrement cnt by 1 on every edge while cnt != 0; on the edge where cnt goes 1->0, copy hi_tmp->E_HI and lo_tmp->E_LO.
REQ-014 SHALL give latency: start sampled at edge k -> E_busy high for cycles k+1..k+N (N=5 or 10), new E_HI/E_LO visible after edge k+N, E_busy low in the same cycle.
REQ-015 SHALL compute MULT as signed 32x32->64 and MULTU as unsigned; HI = product[63:32], LO = product[31:0].
REQ-016 SHALL compute DIV signed: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend; DIVU unsigned.
REQ-017 SHALL for DIV of 0x80000000 by 0xFFFFFFFF produce LO=0x80000000, HI=0.
REQ-018 SHALL for divisor 0 (DIV or DIVU) still run the 10-cycle busy period and leave E_HI/E_LO unchanged at its end.
REQ-019 SHALL ignore E_start while cnt != 0 (no restart, no reload, operands not recaptured).
REQ-020 SHALL execute MTHI (E_HI<=E_WD1) or MTLO (E_LO<=E_WD1) at the edge where the op is present, only when cnt=0; ignored while busy.
REQ-021 SHALL ignore E_start when op is not 1..4; for MTHI/MTLO, E_start is don't-care.
REQ-022 SHALL, when the final busy edge (cnt 1->0) coincides with a presented MTHI/MTLO, perform the MD commit and ignore the MT write.
REQ-023 SHALL keep E_HI/E_LO stable whenever no commit or MT write occurs, including while pipeline flush zeros the instruction (op=0).

Reset
REQ-024 SHALL, while reset=0, force cnt=0, E_busy=0, E_HI=0, E_LO=0, hi_tmp=0, lo_tmp=0, asynchronously.
REQ-025 SHALL abort any in-flight operation on reset; no partial commit after reset releases.
REQ-026 SHALL accept a new E_start on the first rising edge after reset returns to 1.

Verification
REQ-027 MULT A=0xFFFFFFFE (-2), B=3, start at edge k -> busy cycles k+1..k+5; after edge k+5 HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-028 DIVU A=7, B=2 then, at edge k+3, DIV A=5 B=1 with start -> second ignored; after edge k+10 LO=3, HI=1, busy=0.
REQ-029 DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-030 DIVU A=9, B=0 with HI=0x11, LO=0x22 -> busy 10 cycles; HI=0x11, LO=0x22 afterward.
REQ-031 MTHI A=0x1234 idle -> HI=0x1234 next edge, MFHI -> E_MDUResult=0x1234; MTLO during busy -> LO unchanged.
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF, reset pulsed low mid-cycle at k+3 -> busy=0, HI=LO=0 immediately, no commit at k+5.

Source files
------------

// File: rtl/e_mdu.sv
// Multiply/divide unit: fixed-latency MULT/DIV with a down-counter busy window,
// committing HI/LO on the last busy edge; MTHI/MTLO write directly when idle.
module e_mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic        E_start,
    input  logic [31:0] E_WD1,
    input  logic [31:0] E_WD2,
    output logic        E_busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO,
    output logic [31:0] E_MDUResult
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_e;

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

    mdu_op_e     op;
    logic [3:0]  cnt;
    logic [31:0] hi_tmp;
    logic [31:0] lo_tmp;
    logic        commit_en;

    logic        idle;
    logic        is_mul;
    logic        is_div;
    logic        is_signed;
    logic        launch;

    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        case (E_MDUOp)
            4'd1:    op = OP_MULT;
            4'd2:    op = OP_MULTU;
            4'd3:    op = OP_DIV;
            4'd4:    op = OP_DIVU;
            4'd5:    op = OP_MTHI;
            4'd6:    op = OP_MTLO;
            4'd7:    op = OP_MFHI;
            4'd8:    op = OP_MFLO;
            default: op = OP_NONE;
        endcase
    end

    assign idle      = (cnt == '0);
    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign launch    = E_start && idle && (is_mul || is_div);
    assign E_busy    = !idle;

    // A 64-bit product of sign-/zero-extended operands serves both MULT and MULTU.
    assign prod = {{32{is_signed & E_WD1[31]}}, E_WD1} * {{32{is_signed & E_WD2[31]}}, E_WD2};

    // Signed division works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        a_mag = (is_signed && E_WD1[31]) ? ('0 - E_WD1) : E_WD1;
        b_mag = (is_signed && E_WD2[31]) ? ('0 - E_WD2) : E_WD2;
        if (b_mag == '0) begin
            q_mag = '0;
            r_mag = '0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quo = (is_signed && (E_WD1[31] ^ E_WD2[31])) ? ('0 - q_mag) : q_mag;
        rem = (is_signed && E_WD1[31]) ? ('0 - r_mag) : r_mag;
    end

    always_comb begin
        if (is_mul) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            hi_tmp    <= '0;
            lo_tmp    <= '0;
            commit_en <= 1'b0;
            E_HI      <= '0;
            E_LO      <= '0;
        end else if (!idle) begin
            cnt <= cnt - 4'd1;
            if ((cnt == 4'd1) && commit_en) begin
                E_HI <= hi_tmp;
                E_LO <= lo_tmp;
            end
        end else if (launch) begin
            cnt       <= is_mul ? MUL_CYCLES : DIV_CYCLES;
            hi_tmp    <= res_hi;
            lo_tmp    <= res_lo;
            commit_en <= !(is_div && (E_WD2 == '0));
        end else if (op == OP_MTHI) begin
            E_HI <= E_WD1;
        end else if (op == OP_MTLO) begin
            E_LO <= E_WD1;
        end
    end

    always_comb begin
        case (op)
            OP_MFHI: E_MDUResult = E_HI;
            OP_MFLO: E_MDUResult = E_LO;
            default: E_MDUResult = '0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed scenarios plus randomized ops
// checked against an arithmetic reference model of HI/LO.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDUOp;
    logic        E_start;
    logic [31:0] E_WD1;
    logic [31:0] E_WD2;
    logic        E_busy;
    logic [31:0] E_HI;
    logic [31:0] E_LO;
    logic [31:0] E_MDUResult;

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    e_mdu dut (
        .clk        (clk),
        .reset      (reset),
        .E_MDUOp    (E_MDUOp),
        .E_start    (E_start),
        .E_WD1      (E_WD1),
        .E_WD2      (E_WD2),
        .E_busy     (E_busy),
        .E_HI       (E_HI),
        .E_LO       (E_LO),
        .E_MDUResult(E_MDUResult)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic st, input logic [31:0] a, input logic [31:0] b);
        E_MDUOp = op;
        E_start = st;
        E_WD1   = a;
        E_WD2   = b;
    endtask

    // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] hi, inout logic [31:0] lo);
        longint sa, sb, p;
        longint unsigned up;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            4'd2: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
            4'd3: if (b != 0) begin
                      p = sa / sb; lo = p[31:0];
                      p = sa % sb; hi = p[31:0];
                  end
            4'd4: if (b != 0) begin lo = a / b; hi = a % b; end
            4'd5: hi = a;
            4'd6: lo = a;
            default: ;
        endcase
    endfunction

    function automatic int unsigned latency(input logic [3:0] op);
        return (op <= 4'd2) ? 5 : 10;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd1;
            3: return $urandom_range(0, 20);
            4: return 32'h0 - $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        drive(4'd7, 1'b0, '0, '0);
        #3;
        vectors++;
        if (E_busy !== 1'b0 || E_HI !== 32'h0 || E_LO !== 32'h0 || E_MDUResult !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h res=%h, want 0/0/0/0", E_busy, E_HI, E_LO, E_MDUResult);
        end
        tick();
        @(negedge clk);
        reset = 1'b1;
        drive(4'd0, 1'b0, '0, '0);
        tick();
        vectors++;
        if (E_busy !== 1'b0 || E_HI !== 32'h0 || E_LO !== 32'h0) begin
            errors++;
            $display("FAIL reset_release: busy=%b hi=%h lo=%h, want 0/0/0", E_busy, E_HI, E_LO);
        end
    endtask

    task automatic test_mult_directed();
        drive(4'd1, 1'b1, 32'hFFFF_FFFE, 32'd3);
        tick();
        drive(4'd0, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (E_busy !== 1'b1 || E_HI !== hi_m || E_LO !== lo_m) begin
                errors++;
                $display("FAIL mult_busy[%0d]: busy=%b hi=%h lo=%h, want 1/%h/%h", i, E_busy, E_HI, E_LO, hi_m, lo_m);
            end
            tick();
        end
        hi_m = 32'hFFFF_FFFF;
        lo_m = 32'hFFFF_FFFA;
        vectors++;
        if (E_busy !== 1'b0 || E_HI !== hi_m || E_LO !== lo_m) begin
            errors++;
            $display("FAIL mult_result: busy=%b hi=%h lo=%h, want 0/%h/%h", E_busy, E_HI, E_LO, hi_m, lo_m);
        end
    endtask

    task automatic test_back_to_back();
        drive(4'd4, 1'b1, 32'd7, 32'd2);
        tick();
        for (int i = 1; i <= 10; i++) begin
            vectors++;
            if (E_busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_busy[%0d]: busy=%b, want 1", i, E_busy);
            end
            if (i == 3) drive(4'd3, 1'b1, 32'd5, 32'd1);
            else        drive(4'd0, 1'b0, '0, '0);
            tick();
        end
        hi_m = 32'd1;
        lo_m = 32'd3;
        vectors++;
        if (E_busy !== 1'b0 || E_HI !== hi_m || E_LO !== lo_m) begin
            errors++;
            $display("FAIL b2b_result: busy=%b hi=%h lo=%h, want 0/%h/%h", E_busy, E_HI, E_LO, hi_m, lo_m);
        end
        tick();
        vectors++;
        if (E_busy !== 1'b0 || E_HI !== hi_m || E_LO !== lo_m) begin
            errors++;
            $display("FAIL b2b_no_restart: busy=%b hi=%h lo=%h", E_busy, E_HI, E_LO);
        end
    endtask

    task automatic test_div_directed();
        logic [31:0] av [2];
        logic [31:0] hv [2];
        logic [31:0] lv [2];
        av[0] = 32'hFFFF_FFF9; hv[0] = 32'hFFFF_FFFF; lv[0] = 32'hFFFF_FFFD;
        av[1] = 32'h8000_0000; hv[1] = 32'h0;         lv[1] = 32'h8000_0000;
        for (int t = 0; t < 2; t++) begin
            drive(4'd3, 1'b1, av[t], (t == 0) ? 32'd2 : 32'hFFFF_FFFF);
            tick();
            drive(4'd0, 1'b0, '0, '0);
            for (int i = 0; i < 10; i++) tick();
            hi_m = hv[t];
            lo_m = lv[t];
            vectors++;
            if (E_busy !== 1'b0 || E_HI !== hi_m || E_LO !== lo_m) begin
                errors++;
                $display("FAIL div_signed[%0d]: busy=%b hi=%h lo=%h, want 0/%h/%h", t, E_busy, E_HI, E_LO, hi_m, lo_m);
            end
        end
    endtask

    task automatic test_div_zero();
        drive(4'd5, 1'b0, 32'h11, '0);
        tick();
        drive(4'd6, 1'b1, 32'h22, '0);
        tick();
        hi_m = 32'h11;
        lo_m = 32'h22;
        drive(4'd4, 1'b1, 32'd9, 32'd0);
        tick();
        drive(4'd0, 1'b0, '0, '0);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (E_busy !== 1'b1) begin
                errors++;
                $display("FAIL divzero_busy[%0d]: busy=%b, want 1", i, E_busy);
            end
            tick();
        end
        vectors++;
        if (E_busy !== 1'b0 || E_HI !== hi_m || E_LO !== lo_m) begin
            errors++;
            $display("FAIL divzero_result: busy=%b hi=%h lo=%h, want 0/%h/%h", E_busy, E_HI, E_LO, hi_m, lo_m);
        end
    endtask

    task automatic test_mt_mf();
        drive(4'd5, 1'b0, 32'h1234, '0);
        tick();
        hi_m = 32'h1234;
        drive(4'd7, 1'b0, '0, '0);
        #1;
        vectors++;
        if (E_HI !== hi_m || E_MDUResult !== 32'h1234) begin
            errors++;
            $display("FAIL mthi_mfhi: hi=%h res=%h, want %h/00001234", E_HI, E_MDUResult, hi_m);
        end
        drive(4'd8, 1'b0, '0, '0);
        #1;
        vectors++;
        if (E_MDUResult !== lo_m) begin
            errors++;
            $display("FAIL mflo: res=%h, want %h", E_MDUResult, lo_m);
        end
        // MTLO while busy is dropped; MTHI on the final busy edge loses to the commit.
        drive(4'd1, 1'b1, 32'd3, 32'd4);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 1)      drive(4'd6, 1'b0, 32'hBEEF, '0);
            else if (i == 4) drive(4'd5, 1'b0, 32'hDEAD, '0);
            else             drive(4'd0, 1'b0, '0, '0);
            tick();
            if (i == 1) begin
                vectors++;
                if (E_LO !== lo_m) begin
                    errors++;
                    $display("FAIL mtlo_busy: lo=%h, want %h", E_LO, lo_m);
                end
            end
        end
        drive(4'd0, 1'b0, '0, '0);
        hi_m = 32'd0;
        lo_m = 32'd12;
        vectors++;
        if (E_busy !== 1'b0 || E_HI !== hi_m || E_LO !== lo_m) begin
            errors++;
            $display("FAIL mt_final_edge: busy=%b hi=%h lo=%h, want 0/%h/%h", E_busy, E_HI, E_LO, hi_m, lo_m);
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b;
        int unsigned n;
        for (int it = 0; it < 80; it++) begin
            op = 4'($urandom_range(0, 8));
            a  = rand_operand();
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : rand_operand();
            if (op >= 4'd1 && op <= 4'd4) begin
                drive(op, 1'b1, a, b);
                tick();
                n = latency(op);
                for (int i = 0; i < int'(n); i++) begin
                    vectors++;
                    if (E_busy !== 1'b1 || E_HI !== hi_m || E_LO !== lo_m) begin
                        errors++;
                        $display("FAIL rand_busy[%0d.%0d] op=%0d: busy=%b hi=%h lo=%h, want 1/%h/%h",
                                 it, i, op, E_busy, E_HI, E_LO, hi_m, lo_m);
                    end
                    drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom, $urandom);
                    tick();
                end
                drive(4'd0, 1'b0, '0, '0);
                model(op, a, b, hi_m, lo_m);
                vectors++;
                if (E_busy !== 1'b0 || E_HI !== hi_m || E_LO !== lo_m) begin
                    errors++;
                    $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: busy=%b hi=%h lo=%h, want 0/%h/%h",
                             it, op, a, b, E_busy, E_HI, E_LO, hi_m, lo_m);
                end
            end else if (op == 4'd5 || op == 4'd6) begin
                drive(op, 1'($urandom_range(0, 1)), a, b);
                tick();
                drive(4'd0, 1'b0, '0, '0);
                model(op, a, b, hi_m, lo_m);
                vectors++;
                if (E_busy !== 1'b0 || E_HI !== hi_m || E_LO !== lo_m) begin
                    errors++;
                    $display("FAIL rand_mt[%0d] op=%0d: busy=%b hi=%h lo=%h, want 0/%h/%h",
                             it, op, E_busy, E_HI, E_LO, hi_m, lo_m);
                end
            end else if (op == 4'd7 || op == 4'd8) begin
                drive(op, 1'($urandom_range(0, 1)), a, b);
                #1;
                vectors++;
                if (E_MDUResult !== ((op == 4'd7) ? hi_m : lo_m)) begin
                    errors++;
                    $display("FAIL rand_mf[%0d] op=%0d: res=%h, want %h", it, op, E_MDUResult,
                             (op == 4'd7) ? hi_m : lo_m);
                end
                tick();
            end else begin
                op = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(9, 15));
                drive(op, 1'b1, a, b);
                #1;
                vectors++;
                if (E_MDUResult !== 32'd0) begin
                    errors++;
                    $display("FAIL rand_none_res[%0d] op=%0d: res=%h, want 0", it, op, E_MDUResult);
                end
                tick();
                drive(4'd0, 1'b0, '0, '0);
                vectors++;
                if (E_busy !== 1'b0 || E_HI !== hi_m || E_LO !== lo_m) begin
                    errors++;
                    $display("FAIL rand_none[%0d] op=%0d: busy=%b hi=%h lo=%h, want 0/%h/%h",
                             it, op, E_busy, E_HI, E_LO, hi_m, lo_m);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        drive(4'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        drive(4'd0, 1'b0, '0, '0);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        hi_m = '0;
        lo_m = '0;
        vectors++;
        if (E_busy !== 1'b0 || E_HI !== 32'h0 || E_LO !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: busy=%b hi=%h lo=%h, want 0/0/0", E_busy, E_HI, E_LO);
        end
        tick();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (E_busy !== 1'b0 || E_HI !== 32'h0 || E_LO !== 32'h0) begin
                errors++;
                $display("FAIL reset_no_commit[%0d]: busy=%b hi=%h lo=%h, want 0/0/0", i, E_busy, E_HI, E_LO);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive(4'd1, 1'b1, 32'd5, 32'd7);
        tick();
        drive(4'd0, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (E_busy !== 1'b1) begin
                errors++;
                $display("FAIL start_after_reset[%0d]: busy=%b, want 1", i, E_busy);
            end
            tick();
        end
        lo_m = 32'd35;
        vectors++;
        if (E_busy !== 1'b0 || E_HI !== 32'h0 || E_LO !== lo_m) begin
            errors++;
            $display("FAIL post_reset_mult: busy=%b hi=%h lo=%h, want 0/0/%h", E_busy, E_HI, E_LO, lo_m);
        end
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_back_to_back();
        test_div_directed();
        test_div_zero();
        test_mt_mf();
        test_random();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
